smith_waterman: RTL and testbench

SMITH_WATERMAN -- requirements
Module: smith_waterman

---
 rtl/sw_pkg.sv | 27 ++
 rtl/sw_cell.sv | 62 ++++++
 rtl/smith_waterman.sv | 232 +++++++++++++++++++++++
 tb/tb_smith_waterman.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared widths, base encoding and controller
// states for the Smith-Waterman scorer. No ports.
package sw_pkg;
  localparam int SRAM_WORD_WIDTH_DEF = 8;
  localparam int SRAM_ADDR_BIT_DEF = 10;
  localparam int CALC_BIT_DEF = 12;
  localparam int MAX_T_NUM_BIT_DEF = 8;
  localparam int MATCH_BIT_DEF = 4;
  localparam int MAX_Q_LEN_DEF = 64;

  typedef logic [1:0] base_t;
  localparam base_t BASE_A = 2'd0;
  localparam base_t BASE_C = 2'd1;
  localparam base_t BASE_G = 2'd2;
  localparam base_t BASE_T = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_QLEN,
    LD_Q,
    RD_TLEN,
    RD_TBASE,
    CALC,
    REPORT,
    DONE
  } sw_state_e;
endpackage

// File: rtl/sw_cell.sv
// sw_cell: one combinational affine-gap local-alignment cell.
// Ports: q_base/t_base bases, h_diag/h_left/e_left/h_up/f_up
// neighbour scores, match/mismatch/alpha/beta costs; h/e/f out.
module sw_cell
  import sw_pkg::*;
#(
  parameter int CALC_BIT  = CALC_BIT_DEF,
  parameter int MATCH_BIT = MATCH_BIT_DEF
) (
  input  base_t                q_base,
  input  base_t                t_base,
  input  logic [CALC_BIT-1:0]  h_diag,
  input  logic [CALC_BIT-1:0]  h_left,
  input  logic [CALC_BIT-1:0]  e_left,
  input  logic [CALC_BIT-1:0]  h_up,
  input  logic [CALC_BIT-1:0]  f_up,
  input  logic [MATCH_BIT-1:0] match,
  input  logic [MATCH_BIT-1:0] mismatch,
  input  logic [MATCH_BIT-1:0] alpha,
  input  logic [MATCH_BIT-1:0] beta,
  output logic [CALC_BIT-1:0]  h,
  output logic [CALC_BIT-1:0]  e,
  output logic [CALC_BIT-1:0]  f
);
  // Subtract, clamping at zero.
  function automatic logic [CALC_BIT-1:0] sub0(
    input logic [CALC_BIT-1:0]  a,
    input logic [MATCH_BIT-1:0] b
  );
    logic [CALC_BIT-1:0] bx;
    bx = CALC_BIT'(b);
    return (a > bx) ? a - bx : '0;
  endfunction

  // Add, saturating at all-ones.
  function automatic logic [CALC_BIT-1:0] add_sat(
    input logic [CALC_BIT-1:0]  a,
    input logic [MATCH_BIT-1:0] b
  );
    logic [CALC_BIT:0] s;
    s = {1'b0, a} + (CALC_BIT+1)'(b);
    return s[CALC_BIT] ? '1 : s[CALC_BIT-1:0];
  endfunction

  function automatic logic [CALC_BIT-1:0] max2(
    input logic [CALC_BIT-1:0] a,
    input logic [CALC_BIT-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [CALC_BIT-1:0] d;

  always_comb begin
    e = max2(sub0(h_left, alpha), sub0(e_left, beta));
    f = max2(sub0(h_up, alpha), sub0(f_up, beta));
    d = (q_base == t_base) ? add_sat(h_diag, match)
                           : sub0(h_diag, mismatch);
    // Unsigned values already floor the result at 0.
    h = max2(d, max2(e, f));
  end
endmodule

// File: rtl/smith_waterman.sv
// smith_waterman: scores each query against every target, one cell
// per clock, reading both lists through one zero-wait port.
// Ports: clk, rst (sync, high), start_i, busy_o, select_T_o, addr_o,
// data_i, match_i/mismatch_i/alpha_i/beta_i, result_o, valid_o,
// change_q_o, max_result_o, match_idx_o.
// BEST_TRACK_EN: compile best-score/index tracking (else tied to 0).
module smith_waterman
  import sw_pkg::*;
#(
  parameter int SRAM_WORD_WIDTH = SRAM_WORD_WIDTH_DEF,
  parameter int SRAM_ADDR_BIT   = SRAM_ADDR_BIT_DEF,
  parameter int CALC_BIT        = CALC_BIT_DEF,
  parameter int MAX_T_NUM_BIT   = MAX_T_NUM_BIT_DEF,
  parameter int MATCH_BIT       = MATCH_BIT_DEF,
  parameter int MAX_Q_LEN       = MAX_Q_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       select_T_o,
  output logic [SRAM_ADDR_BIT-1:0]   addr_o,
  input  logic [SRAM_WORD_WIDTH-1:0] data_i,
  input  logic [MATCH_BIT-1:0]       match_i,
  input  logic [MATCH_BIT-1:0]       mismatch_i,
  input  logic [MATCH_BIT-1:0]       alpha_i,
  input  logic [MATCH_BIT-1:0]       beta_i,
  output logic [CALC_BIT-1:0]        result_o,
  output logic                       valid_o,
  output logic                       change_q_o,
  output logic [CALC_BIT-1:0]        max_result_o,
  output logic [MAX_T_NUM_BIT-1:0]   match_idx_o
);
  localparam int WW = SRAM_WORD_WIDTH;
  localparam int AW = SRAM_ADDR_BIT;
  localparam int CB = CALC_BIT;
  localparam int CW = (MAX_Q_LEN > 1) ? $clog2(MAX_Q_LEN) : 1;
  localparam logic [WW-1:0] W1 = WW'(1);
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [WW-1:0] QMAX = WW'(MAX_Q_LEN);

  sw_state_e state, state_nx;

  logic [AW-1:0] q_addr, t_addr;
  logic [WW-1:0] qlen, qn, tlen, cnt, tr, ci;
  logic [CW-1:0] col, ld;
  base_t         q_mem [MAX_Q_LEN];
  base_t         t_base;
  logic [CB-1:0] h_row [MAX_Q_LEN];
  logic [CB-1:0] f_row [MAX_Q_LEN];
  logic [CB-1:0] h_diag, h_left, e_left, score;
  logic [CB-1:0] h, e, f;
  logic zero_word, last_load, last_cell, last_row, new_tgt;

  // Queries longer than MAX_Q_LEN are truncated for scoring.
  assign qn = (int'(qlen) > MAX_Q_LEN) ? QMAX : qlen;
  assign col = ci[CW-1:0];
  assign ld = cnt[CW-1:0];
  assign zero_word = (data_i == '0);
  assign last_load = (cnt == qlen - W1);
  assign last_cell = (ci == qn - W1);
  assign last_row = (tr == tlen - W1);
  // REPORT doubles as the read of the next target length.
  assign new_tgt = !zero_word &&
                   (state == RD_TLEN || state == REPORT);

  sw_cell #(
    .CALC_BIT (CB),
    .MATCH_BIT(MATCH_BIT)
  ) u_cell (
    .q_base  (q_mem[col]),
    .t_base  (t_base),
    .h_diag  (h_diag),
    .h_left  (h_left),
    .e_left  (e_left),
    .h_up    (h_row[col]),
    .f_up    (f_row[col]),
    .match   (match_i),
    .mismatch(mismatch_i),
    .alpha   (alpha_i),
    .beta    (beta_i),
    .h       (h),
    .e       (e),
    .f       (f)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start_i) state_nx = RD_QLEN;
      RD_QLEN:  state_nx = zero_word ? DONE : LD_Q;
      LD_Q:     if (last_load) state_nx = RD_TLEN;
      RD_TLEN:  state_nx = zero_word ? IDLE : RD_TBASE;
      RD_TBASE: state_nx = CALC;
      CALC:
        if (last_cell)
          state_nx = last_row ? REPORT : RD_TBASE;
      REPORT:   state_nx = zero_word ? RD_QLEN : RD_TBASE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    select_T_o = 1'b0;
    unique case (state)
      RD_TLEN, RD_TBASE, REPORT: select_T_o = 1'b1;
      default: select_T_o = 1'b0;
    endcase
    addr_o = select_T_o ? t_addr : q_addr;
  end

  // Query bases and the previous DP row; no reset needed as
  // every target clears the row before use.
  always_ff @(posedge clk) begin
    if (state == LD_Q && int'(cnt) < MAX_Q_LEN)
      q_mem[ld] <= data_i[1:0];
    if (new_tgt) begin
      for (int i = 0; i < MAX_Q_LEN; i++) begin
        h_row[i] <= '0;
        f_row[i] <= '0;
      end
    end else if (state == CALC) begin
      h_row[col] <= h;
      f_row[col] <= f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_addr     <= '0;
      t_addr     <= '0;
      qlen       <= '0;
      tlen       <= '0;
      cnt        <= '0;
      tr         <= '0;
      ci         <= '0;
      t_base     <= '0;
      h_diag     <= '0;
      h_left     <= '0;
      e_left     <= '0;
      score      <= '0;
      result_o   <= '0;
      valid_o    <= 1'b0;
      change_q_o <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      change_q_o <= 1'b0;
      unique case (state)
        IDLE:
          if (start_i) begin
            q_addr <= '0;
            t_addr <= '0;
          end
        RD_QLEN:
          if (!zero_word) begin
            qlen   <= data_i;
            q_addr <= q_addr + A1;
            cnt    <= '0;
          end
        LD_Q: begin
          q_addr <= q_addr + A1;
          cnt    <= cnt + W1;
          if (last_load) t_addr <= '0;
        end
        RD_TBASE: begin
          t_base <= data_i[1:0];
          t_addr <= t_addr + A1;
          ci     <= '0;
          h_diag <= '0;
          h_left <= '0;
          e_left <= '0;
        end
        CALC: begin
          // Old h_row[col] is next cell's diagonal.
          h_diag <= h_row[col];
          h_left <= h;
          e_left <= e;
          if (h > score) score <= h;
          ci <= ci + W1;
          if (last_cell) tr <= tr + W1;
        end
        REPORT: begin
          result_o   <= score;
          valid_o    <= 1'b1;
          change_q_o <= zero_word;
        end
        default: ;
      endcase
      if (new_tgt) begin
        tlen   <= data_i;
        t_addr <= t_addr + A1;
        tr     <= '0;
        score  <= '0;
      end
    end
  end

`ifdef BEST_TRACK_EN
  logic [MAX_T_NUM_BIT-1:0] t_idx;
  logic                     first;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_idx        <= '0;
      first        <= 1'b0;
      max_result_o <= '0;
      match_idx_o  <= '0;
    end else if (state == LD_Q) begin
      t_idx <= '0;
      first <= 1'b1;
    end else if (state == REPORT) begin
      first <= 1'b0;
      t_idx <= t_idx + MAX_T_NUM_BIT'(1);
      // Strict compare keeps the lowest index on ties.
      if (first || score > max_result_o) begin
        max_result_o <= score;
        match_idx_o  <= t_idx;
      end
    end
  end
`else
  assign max_result_o = '0;
  assign match_idx_o  = '0;
`endif
endmodule

// File: tb/tb_smith_waterman.sv
// tb_smith_waterman: directed self-checking bench for
// smith_waterman with hand-computed pair scores.
module tb_smith_waterman;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, select_T_o, valid_o, change_q_o;
  logic [9:0]  addr_o;
  logic [7:0]  data_i;
  logic [3:0]  match_i = 4'd6;
  logic [3:0]  mismatch_i = 4'd1;
  logic [3:0]  alpha_i = 4'd2;
  logic [3:0]  beta_i = 4'd1;
  logic [11:0] result_o, max_result_o;
  logic [7:0]  match_idx_o;

  logic [7:0] qmem [1024];
  logic [7:0] tmem [1024];
  int qa, ta, total, bad;
  int er[$], ec[$], em[$], ei[$];
  int gr[$], gc[$], gm[$], gi[$];

  always #5 clk = ~clk;

  assign data_i = select_T_o ? tmem[addr_o] : qmem[addr_o];

  smith_waterman dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .select_T_o  (select_T_o),
    .addr_o      (addr_o),
    .data_i      (data_i),
    .match_i     (match_i),
    .mismatch_i  (mismatch_i),
    .alpha_i     (alpha_i),
    .beta_i      (beta_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .change_q_o  (change_q_o),
    .max_result_o(max_result_o),
    .match_idx_o (match_idx_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input byte c);
    case (c)
      8'h43:   return 8'd1;
      8'h47:   return 8'd2;
      8'h54:   return 8'd3;
      default: return 8'd0;
    endcase
  endfunction

  task automatic clr();
    for (int i = 0; i < 1024; i++) begin
      qmem[i] = 8'd0;
      tmem[i] = 8'd0;
    end
    qa = 0;
    ta = 0;
  endtask

  task automatic put(input bit tgt, input string s);
    if (tgt) begin
      tmem[ta] = 8'(s.len());
      ta++;
    end else begin
      qmem[qa] = 8'(s.len());
      qa++;
    end
    for (int i = 0; i < s.len(); i++) begin
      if (tgt) begin
        tmem[ta] = enc(s[i]);
        ta++;
      end else begin
        qmem[qa] = enc(s[i]);
        qa++;
      end
    end
  endtask

  task automatic exp_pair(input int r, input int c,
                          input int m, input int i);
    er.push_back(r);
    ec.push_back(c);
`ifdef BEST_TRACK_EN
    em.push_back(m);
    ei.push_back(i);
`else
    em.push_back(0 * m);
    ei.push_back(0 * i);
`endif
  endtask

  task automatic run_job(input string tag, input int extra_at);
    bit done;
    gr.delete(); gc.delete(); gm.delete(); gi.delete();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(negedge clk);
      start_i = (n == extra_at);
      if (valid_o) begin
        gr.push_back(int'(result_o));
        gc.push_back(int'(change_q_o));
        gm.push_back(int'(max_result_o));
        gi.push_back(int'(match_idx_o));
      end
      if (!busy_o) done = 1'b1;
    end
    start_i = 1'b0;
    chk({tag, "_end"}, 32'(done), 32'd1);
    chk({tag, "_npairs"}, gr.size(), er.size());
    for (int k = 0; k < er.size() && k < gr.size(); k++) begin
      chk($sformatf("%s_res%0d", tag, k), gr[k], er[k]);
      chk($sformatf("%s_chq%0d", tag, k), gc[k], ec[k]);
      if (ec[k] == 1) begin
        chk($sformatf("%s_max%0d", tag, k), gm[k], em[k]);
        chk($sformatf("%s_idx%0d", tag, k), gi[k], ei[k]);
      end
    end
    if (er.size() > 0)
      chk({tag, "_hold"}, 32'(result_o), er[er.size()-1]);
    er.delete(); ec.delete(); em.delete(); ei.delete();
  endtask

  initial begin
    string lq;
    int nv;
    total = 0;
    bad = 0;
    clr();

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_chq", 32'(change_q_o), 32'd0);
    chk("rst_max", 32'(max_result_o), 32'd0);
    chk("rst_idx", 32'(match_idx_o), 32'd0);
    chk("rst_sel", 32'(select_T_o), 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    rst = 1'b0;

    // Exact match
    clr();
    put(0, "ACGT");
    put(1, "ACGT");
    exp_pair(24, 1, 24, 0);
    run_job("same", -1);

    // Two targets, gapped alignments
    clr();
    put(0, "ACGT");
    put(1, "AGT");
    put(1, "ACCGT");
    exp_pair(16, 0, 16, 0);
    exp_pair(22, 1, 22, 1);
    run_job("gap", -1);

    // All-mismatch pairs clamp at zero, tie keeps index 0
    clr();
    put(0, "A");
    put(1, "T");
    put(1, "T");
    exp_pair(0, 0, 0, 0);
    exp_pair(0, 1, 0, 0);
    run_job("zero", -1);

    // Nonzero tie keeps lowest index
    clr();
    put(0, "AC");
    put(1, "AC");
    put(1, "AC");
    exp_pair(12, 0, 12, 0);
    exp_pair(12, 1, 12, 0);
    run_job("tie", -1);

    // Two queries against one target
    clr();
    put(0, "AC");
    put(0, "GG");
    put(1, "GGAC");
    exp_pair(12, 1, 12, 0);
    exp_pair(12, 1, 12, 0);
    run_job("twoq", -1);

    // Extra start while busy is ignored
    clr();
    put(0, "ACGT");
    put(1, "AGT");
    put(1, "ACCGT");
    exp_pair(16, 0, 16, 0);
    exp_pair(22, 1, 22, 1);
    run_job("restart", 3);

    // Query over 64 bases: tail A's ignored, next query found
    clr();
    lq = "";
    for (int i = 0; i < 64; i++) lq = {lq, "C"};
    lq = {lq, "AAAAAA"};
    put(0, lq);
    put(0, "AC");
    put(1, "AAA");
    exp_pair(0, 1, 0, 0);
    exp_pair(6, 1, 6, 0);
    run_job("longq", -1);

    // Empty query list
    clr();
    put(1, "ACGT");
    run_job("noq", -1);

    // Empty target list
    clr();
    put(0, "AC");
    run_job("not", -1);

    // Reset in the middle of CALC
    clr();
    put(0, "ACGT");
    put(1, "ACGT");
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy_o), 32'd0);
    chk("mid_valid", 32'(valid_o), 32'd0);
    chk("mid_result", 32'(result_o), 32'd0);
    chk("mid_sel", 32'(select_T_o), 32'd0);
    chk("mid_addr", 32'(addr_o), 32'd0);
    chk("mid_max", 32'(max_result_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (60) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    chk("mid_novalid", nv, 0);
    chk("mid_idle", 32'(busy_o), 32'd0);
    exp_pair(24, 1, 24, 0);
    run_job("rerun", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
